// File: rtl/fns_weight_seq_if.sv
// Handshake and result bundle between the fault-flag source and the FNS weight sequencer.
interface fns_weight_seq_if #(
   parameter int N = 5,
   parameter int W = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic          start;
   logic [N-1:0]  f_flag;
   logic          busy;
   logic          w_valid;
   logic [IW-1:0] w_idx;
   logic [W-1:0]  w_data;
   logic          w_en;
   logic [N-1:0]  en_flag;
   logic          done;
   logic          fail;
   logic          ovf;

   modport master (
      output start, f_flag,
      input  busy, w_valid, w_idx, w_data, w_en, en_flag, done, fail, ovf
   );

   modport slave (
      input  start, f_flag,
      output busy, w_valid, w_idx, w_data, w_en, en_flag, done, fail, ovf
   );
endinterface

// File: rtl/fns_weight_seq.sv
// Sequential Fibonacci-numeral-system weight generator for TSV-group repair.
// One TSV is visited per clock through a single shared saturating adder; the
// first N_SIG healthy TSVs get consecutive Fibonacci weights 1,2,3,5,...
// The step that produces TSV k's report is evaluated in the cycle before it
// is shown, so the first TSV is computed directly from f_flag on the start
// cycle and every output leaves a register.
module fns_weight_seq #(
   parameter int N_SIG = 3,
   parameter int N_RED = 2,
   parameter int W     = 8
) (
   input  logic            clk,
   input  logic            rst,
   fns_weight_seq_if.slave bus
);
   localparam int N  = N_SIG + N_RED;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N_SIG + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Datapath and result registers
   logic [N-1:0]  r_fl;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   logic          r_ovr;
   logic [N-1:0]  r_wvec;
   logic          r_busy;
   logic          r_w_valid;
   logic [IW-1:0] r_w_idx;
   logic [W-1:0]  r_w_data;
   logic          r_w_en;
   logic [N-1:0]  r_en_flag;
   logic          r_done;
   logic          r_fail;
   logic          r_ovf;

   // Step operand selection: a fresh pass starts from the reset Fibonacci state
   logic          w_first;
   logic          w_step;
   logic          w_last;
   logic [N-1:0]  w_src_fl;
   logic [W-1:0]  w_src_a;
   logic [W-1:0]  w_src_b;
   logic [CW-1:0] w_src_cnt;
   logic [IW-1:0] w_src_idx;
   logic [N-1:0]  w_src_vec;
   logic          w_src_ovr;
   logic          w_hit;
   logic [W:0]    w_sum;
   logic [W-1:0]  w_sat;

   // Next values of every register
   logic [N-1:0]  w_fl_nxt;
   logic [W-1:0]  w_a_nxt;
   logic [W-1:0]  w_b_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic          w_ovr_nxt;
   logic [N-1:0]  w_wvec_nxt;
   logic          w_busy_nxt;
   logic          w_w_valid_nxt;
   logic [IW-1:0] w_w_idx_nxt;
   logic [W-1:0]  w_w_data_nxt;
   logic          w_w_en_nxt;
   logic [N-1:0]  w_en_flag_nxt;
   logic          w_done_nxt;
   logic          w_fail_nxt;
   logic          w_ovf_nxt;

   // Clamp a W+1 bit sum to the largest W-bit weight
   function automatic logic [W-1:0] sat_w(input logic [W:0] s);
      return s[W] ? {W{1'b1}} : s[W-1:0];
   endfunction

   assign w_first   = (r_state == S_IDLE);
   assign w_last    = (r_idx == IW'(N - 1));
   assign w_step    = (w_first && bus.start) || ((r_state == S_RUN) && !w_last);
   assign w_src_fl  = w_first ? bus.f_flag : r_fl;
   assign w_src_a   = w_first ? '0 : r_a;
   assign w_src_b   = w_first ? W'(1) : r_b;
   assign w_src_cnt = w_first ? '0 : r_cnt;
   assign w_src_idx = w_first ? '0 : (r_idx + IW'(1));
   assign w_src_vec = w_first ? '0 : r_wvec;
   assign w_src_ovr = w_first ? 1'b0 : r_ovr;
   assign w_hit     = !w_src_fl[w_src_idx] && (w_src_cnt < CW'(N_SIG));
   assign w_sum     = {1'b0, w_src_a} + {1'b0, w_src_b};
   assign w_sat     = sat_w(w_sum);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: RUN spans the N cycles in which TSV reports are visible
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:                 w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values: one TSV step, or the pass summary at the end
   always_comb begin
      w_fl_nxt      = r_fl;
      w_a_nxt       = r_a;
      w_b_nxt       = r_b;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_ovr_nxt     = r_ovr;
      w_wvec_nxt    = r_wvec;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_w_valid_nxt = 1'b0;
      w_w_idx_nxt   = r_w_idx;
      w_w_data_nxt  = r_w_data;
      w_w_en_nxt    = r_w_en;
      w_en_flag_nxt = r_en_flag;
      w_done_nxt    = 1'b0;
      w_fail_nxt    = r_fail;
      w_ovf_nxt     = r_ovf;
      if (w_step) begin
         w_fl_nxt      = w_src_fl;
         w_idx_nxt     = w_src_idx;
         w_w_valid_nxt = 1'b1;
         w_w_idx_nxt   = w_src_idx;
         w_w_en_nxt    = w_hit;
         w_w_data_nxt  = w_hit ? w_sat : '0;
         w_wvec_nxt    = w_src_vec | (N'(w_hit) << w_src_idx);
         w_ovr_nxt     = w_src_ovr | (w_hit & w_sum[W]);
         if (w_hit) begin
            w_a_nxt   = w_src_b;
            w_b_nxt   = w_sat;
            w_cnt_nxt = w_src_cnt + CW'(1);
         end else begin
            w_a_nxt   = w_src_a;
            w_b_nxt   = w_src_b;
            w_cnt_nxt = w_src_cnt;
         end
      end
      if ((r_state == S_RUN) && w_last) begin
         w_done_nxt    = 1'b1;
         w_en_flag_nxt = r_wvec;
         w_fail_nxt    = (r_cnt < CW'(N_SIG));
         w_ovf_nxt     = r_ovr;
      end
   end

   // Register all datapath state and outputs; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fl      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_ovr     <= 1'b0;
         r_wvec    <= '0;
         r_busy    <= 1'b0;
         r_w_valid <= 1'b0;
         r_w_idx   <= '0;
         r_w_data  <= '0;
         r_w_en    <= 1'b0;
         r_en_flag <= '0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_fl      <= w_fl_nxt;
         r_a       <= w_a_nxt;
         r_b       <= w_b_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_ovr     <= w_ovr_nxt;
         r_wvec    <= w_wvec_nxt;
         r_busy    <= w_busy_nxt;
         r_w_valid <= w_w_valid_nxt;
         r_w_idx   <= w_w_idx_nxt;
         r_w_data  <= w_w_data_nxt;
         r_w_en    <= w_w_en_nxt;
         r_en_flag <= w_en_flag_nxt;
         r_done    <= w_done_nxt;
         r_fail    <= w_fail_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.w_valid = r_w_valid;
   assign bus.w_idx   = r_w_idx;
   assign bus.w_data  = r_w_data;
   assign bus.w_en    = r_w_en;
   assign bus.en_flag = r_en_flag;
   assign bus.done    = r_done;
   assign bus.fail    = r_fail;
   assign bus.ovf     = r_ovf;
endmodule
